// File: rtl/fetch_ctrl_mc_if.sv
// Bundle of the decoder/branch-unit inputs and the PC-control outputs of the
// multi-channel fetch controller. The controller uses the slave modport and
// whoever drives the decoder-side signals uses the master modport.
interface fetch_ctrl_mc_if #(
   parameter int NUM_IRQ = 4,
   parameter int VEC_W   = 3,
   parameter int OPC_W   = 4
);
   logic [NUM_IRQ-1:0] irq_req;
   logic               stall_in;
   logic [OPC_W-1:0]   opcode;
   logic [1:0]         brx;
   logic               branch_taken;
   logic               bypass_done;

   logic               pc_en;
   logic               pc_load;
   logic [1:0]         pc_src;
   logic               vec_fetch;
   logic [VEC_W-1:0]   vec_sel;
   logic               sf1;
   logic               stall;
   logic [NUM_IRQ-1:0] irq_ack;

   modport master (
      output irq_req, stall_in, opcode, brx, branch_taken, bypass_done,
      input  pc_en, pc_load, pc_src, vec_fetch, vec_sel, sf1, stall, irq_ack
   );

   modport slave (
      input  irq_req, stall_in, opcode, brx, branch_taken, bypass_done,
      output pc_en, pc_load, pc_src, vec_fetch, vec_sel, sf1, stall, irq_ack
   );
endinterface

// File: rtl/fetch_ctrl_mc.sv
// Fetch-stage PC controller with prioritised vectored interrupts, multi-word
// instruction sequencing, branch/jump/return loading and a fixed return-memory
// latency wait. Bit 0 of the interrupt request vector has the highest priority.
module fetch_ctrl_mc #(
   parameter int NUM_IRQ   = 4,
   parameter int VEC_W     = 3,
   parameter int OPC_W     = 4,
   parameter int EXT_OPC   = 12,
   parameter int EXT_WORDS = 1,
   parameter int BR_OPC    = 11,
   parameter int RET_WAIT  = 2
) (
   input logic            clk,
   input logic            reset,
   fetch_ctrl_mc_if.slave bus
);

   localparam int CNT_MAX = (EXT_WORDS > RET_WAIT) ? EXT_WORDS : RET_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [OPC_W-1:0] EXT_CODE = OPC_W'(EXT_OPC);
   localparam logic [OPC_W-1:0] BR_CODE  = OPC_W'(BR_OPC);
   localparam logic [CNT_W-1:0] EXT_LAST = CNT_W'(EXT_WORDS - 1);
   localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_WAIT);

   typedef enum logic [2:0] {
      S_RESET,
      S_FETCH,
      S_EXT,
      S_WAIT,
      S_BRANCH,
      S_VECTOR
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pcWasLoaded_q, pcWasLoaded_d;
   logic [VEC_W-1:0]   vecIdx_q, vecIdx_d;

   logic [VEC_W-1:0]   lowestIdx;
   logic               isExt;
   logic               isBr;

   logic               pcEn;
   logic               pcLoad;
   logic [1:0]         pcSrc;
   logic               vecFetch;
   logic [VEC_W-1:0]   vecSel;
   logic               sf1;
   logic               stallOut;
   logic [NUM_IRQ-1:0] irqAck;

   assign isExt = (bus.opcode == EXT_CODE);
   assign isBr  = (bus.opcode == BR_CODE);

   // Priority encoder: scanning from the top down leaves the lowest set
   // pending bit, i.e. the highest-priority channel.
   always_comb begin
      lowestIdx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            lowestIdx = VEC_W'(i);
         end
      end
   end

   // Next-state and output decode; every output idles at 0 unless a state
   // explicitly drives it, and stall_in freezes progress wherever it applies.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      vecIdx_d = vecIdx_q;
      pcEn     = 1'b0;
      pcLoad   = 1'b0;
      pcSrc    = 2'b00;
      vecFetch = 1'b0;
      vecSel   = '0;
      sf1      = 1'b0;
      stallOut = 1'b0;
      irqAck   = '0;

      case (state_q)
         S_RESET: begin
            pcEn     = 1'b1;
            pcLoad   = 1'b1;
            pcSrc    = 2'b01;
            vecFetch = 1'b1;
            vecSel   = '0;
            state_d  = S_FETCH;
         end

         S_FETCH: begin
            if (!bus.stall_in) begin
               pcEn = !pcWasLoaded_q;
               if ((pending_q != '0) && !isExt && !isBr && !bus.branch_taken) begin
                  state_d  = S_VECTOR;
                  vecIdx_d = lowestIdx;
               end else if (isExt) begin
                  state_d = S_EXT;
                  cnt_d   = '0;
               end else if (bus.branch_taken || (isBr && !bus.brx[1])) begin
                  state_d = S_BRANCH;
               end else if (isBr) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end
            end
         end

         S_EXT: begin
            if (!bus.stall_in) begin
               pcEn  = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == EXT_LAST) begin
                  state_d = S_FETCH;
               end
            end
         end

         S_WAIT: begin
            if (cnt_q == RET_LAST) begin
               state_d = S_BRANCH;
            end else begin
               stallOut = 1'b1;
               if (!bus.stall_in) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         S_BRANCH: begin
            if (!bus.stall_in) begin
               if (bus.branch_taken) begin
                  pcEn    = 1'b1;
                  pcLoad  = 1'b1;
                  pcSrc   = 2'b00;
                  state_d = S_FETCH;
               end else if (isBr && bus.brx[1]) begin
                  pcEn    = 1'b1;
                  pcLoad  = 1'b1;
                  pcSrc   = 2'b11;
                  state_d = S_FETCH;
               end else if (isBr && bus.bypass_done) begin
                  pcEn    = 1'b1;
                  pcLoad  = 1'b1;
                  pcSrc   = 2'b10;
                  state_d = S_FETCH;
               end else if (isBr) begin
                  stallOut = 1'b1;
               end
            end
         end

         S_VECTOR: begin
            pcEn     = 1'b1;
            pcLoad   = 1'b1;
            pcSrc    = 2'b01;
            vecFetch = 1'b1;
            vecSel   = vecIdx_q + VEC_W'(1);
            sf1      = 1'b1;
            irqAck   = NUM_IRQ'(1) << vecIdx_q;
            state_d  = S_FETCH;
         end

         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   // Acknowledged channels clear, new requests set; a requester still high
   // during its acknowledge simply re-pends.
   always_comb begin
      pending_d     = (pending_q & ~irqAck) | bus.irq_req;
      pcWasLoaded_d = pcEn & pcLoad;
   end

   // State registers; reset discards pending interrupts and marks the PC as
   // just loaded so the first fetch does not increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_RESET;
         pending_q     <= '0;
         cnt_q         <= '0;
         pcWasLoaded_q <= 1'b1;
         vecIdx_q      <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         cnt_q         <= cnt_d;
         pcWasLoaded_q <= pcWasLoaded_d;
         vecIdx_q      <= vecIdx_d;
      end
   end

   assign bus.pc_en     = pcEn;
   assign bus.pc_load   = pcLoad;
   assign bus.pc_src    = pcSrc;
   assign bus.vec_fetch = vecFetch;
   assign bus.vec_sel   = vecSel;
   assign bus.sf1       = sf1;
   assign bus.stall     = stallOut;
   assign bus.irq_ack   = irqAck;

endmodule

// File: tb/tb_fetch_ctrl_mc.sv
// Directed bench for fetch_ctrl_mc with EXT_WORDS=2 and RET_WAIT=2: a cycle
// table for reset, interrupts, jumps and taken branches, then hand-written
// sequences for multi-word fetch, return latency and mid-operation reset.
module tb_fetch_ctrl_mc;

   typedef struct packed {
      logic       rstN;
      logic [3:0] irq;
      logic       stallIn;
      logic [3:0] opc;
      logic [1:0] brx;
      logic       bt;
      logic       byp;
   } ins_t;

   typedef struct packed {
      logic       pcEn;
      logic       pcLoad;
      logic [1:0] pcSrc;
      logic       vecFetch;
      logic [2:0] vecSel;
      logic       sf1;
      logic       stall;
      logic [3:0] irqAck;
   } outs_t;

   typedef struct {
      string name;
      ins_t  in;
      outs_t exp;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   extEnCount;
   int   retStallCount;
   vec_t tbl[$];
   outs_t oRst, oZero, oInc, oStall;

   fetch_ctrl_mc_if #(.NUM_IRQ(4), .VEC_W(3), .OPC_W(4)) bus ();

   fetch_ctrl_mc #(
      .NUM_IRQ  (4),
      .VEC_W    (3),
      .OPC_W    (4),
      .EXT_OPC  (12),
      .EXT_WORDS(2),
      .BR_OPC   (11),
      .RET_WAIT (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ins_t mkIn(input logic rstN, input logic [3:0] irq,
                                 input logic stallIn, input logic [3:0] opc,
                                 input logic [1:0] brx, input logic bt,
                                 input logic byp);
      ins_t v;
      v.rstN = rstN; v.irq = irq; v.stallIn = stallIn; v.opc = opc;
      v.brx = brx; v.bt = bt; v.byp = byp;
      return v;
   endfunction

   function automatic outs_t mkOut(input logic en, input logic ld,
                                   input logic [1:0] src, input logic vf,
                                   input logic [2:0] vsel, input logic s1,
                                   input logic st, input logic [3:0] ack);
      outs_t o;
      o.pcEn = en; o.pcLoad = ld; o.pcSrc = src; o.vecFetch = vf;
      o.vecSel = vsel; o.sf1 = s1; o.stall = st; o.irqAck = ack;
      return o;
   endfunction

   function automatic outs_t getOut();
      outs_t o;
      o.pcEn = bus.pc_en; o.pcLoad = bus.pc_load; o.pcSrc = bus.pc_src;
      o.vecFetch = bus.vec_fetch; o.vecSel = bus.vec_sel; o.sf1 = bus.sf1;
      o.stall = bus.stall; o.irqAck = bus.irq_ack;
      return o;
   endfunction

   task automatic addRow(input string n, input ins_t i, input outs_t o);
      vec_t v;
      v.name = n; v.in = i; v.exp = o;
      tbl.push_back(v);
   endtask

   task automatic applyStimulus(input ins_t i);
      reset            = i.rstN;
      bus.irq_req      = i.irq;
      bus.stall_in     = i.stallIn;
      bus.opcode       = i.opc;
      bus.brx          = i.brx;
      bus.branch_taken = i.bt;
      bus.bypass_done  = i.byp;
   endtask

   task automatic checkOutput(input string n, input outs_t exp);
      outs_t act;
      act = getOut();
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%b required=%b (en ld src vf vsel sf1 stall ack)",
                  n, act, exp);
      end
   endtask

   task automatic checkValue(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", n, act, exp);
      end
   endtask

   // One cycle: drive just after the rising edge, sample on the falling edge.
   task automatic runRow(input string n, input ins_t i, input outs_t exp);
      applyStimulus(i);
      @(negedge clk);
      checkOutput(n, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      oRst   = mkOut(1, 1, 2'b01, 1, 3'd0, 0, 0, 4'b0000);
      oZero  = mkOut(0, 0, 2'b00, 0, 3'd0, 0, 0, 4'b0000);
      oInc   = mkOut(1, 0, 2'b00, 0, 3'd0, 0, 0, 4'b0000);
      oStall = mkOut(0, 0, 2'b00, 0, 3'd0, 0, 1, 4'b0000);

      // Reset release and NOP increment behaviour.
      addRow("rst_held",     mkIn(0, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oRst);
      addRow("rst_vector",   mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oRst);
      addRow("fetch_noinc",  mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      addRow("fetch_inc1",   mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);
      addRow("fetch_inc2",   mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);
      // Two requests: channel 1 wins, channel 3 follows.
      addRow("irq_sample",   mkIn(1, 4'b1010, 0, 4'd0, 2'd0, 0, 0), oInc);
      addRow("irq_accept",   mkIn(1, 4'b1010, 0, 4'd0, 2'd0, 0, 0), oInc);
      addRow("irq1_vector",  mkIn(1, 4'b1000, 0, 4'd0, 2'd0, 0, 0),
             mkOut(1, 1, 2'b01, 1, 3'd2, 1, 0, 4'b0010));
      addRow("irq3_accept",  mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      addRow("irq3_vector",  mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0),
             mkOut(1, 1, 2'b01, 1, 3'd4, 1, 0, 4'b1000));
      addRow("post_irq_noinc", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      addRow("post_irq_inc", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);
      // JMP waiting three cycles for bypass.
      addRow("jmp_fetch",    mkIn(1, 4'b0000, 0, 4'd11, 2'd0, 0, 0), oInc);
      addRow("jmp_wait1",    mkIn(1, 4'b0000, 0, 4'd11, 2'd0, 0, 0), oStall);
      addRow("jmp_wait2",    mkIn(1, 4'b0000, 0, 4'd11, 2'd0, 0, 0), oStall);
      addRow("jmp_wait3",    mkIn(1, 4'b0000, 0, 4'd11, 2'd0, 0, 0), oStall);
      addRow("jmp_load",     mkIn(1, 4'b0000, 0, 4'd11, 2'd0, 0, 1),
             mkOut(1, 1, 2'b10, 0, 3'd0, 0, 0, 4'b0000));
      addRow("jmp_noinc",    mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      addRow("jmp_inc",      mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);
      // Taken conditional branch.
      addRow("bt_fetch",     mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 1, 0), oInc);
      addRow("bt_load",      mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 1, 0),
             mkOut(1, 1, 2'b00, 0, 3'd0, 0, 0, 4'b0000));
      addRow("bt_noinc",     mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      addRow("bt_inc",       mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);
      // stall_in holds S_BRANCH and S_FETCH.
      addRow("bts_fetch",    mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 1, 0), oInc);
      addRow("bts_stalled",  mkIn(1, 4'b0000, 1, 4'd0, 2'd0, 1, 0), oZero);
      addRow("bts_load",     mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 1, 0),
             mkOut(1, 1, 2'b00, 0, 3'd0, 0, 0, 4'b0000));
      addRow("bts_noinc",    mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      addRow("fetch_stalled", mkIn(1, 4'b0000, 1, 4'd0, 2'd0, 0, 0), oZero);
      addRow("fetch_resume", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);
      // A pending request is not taken on a taken-branch fetch.
      addRow("irq0_sample",  mkIn(1, 4'b0001, 0, 4'd0, 2'd0, 0, 0), oInc);
      addRow("irq0_blocked", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 1, 0), oInc);
      addRow("irq0_brload",  mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 1, 0),
             mkOut(1, 1, 2'b00, 0, 3'd0, 0, 0, 4'b0000));
      addRow("irq0_accept",  mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      addRow("irq0_vector",  mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0),
             mkOut(1, 1, 2'b01, 1, 3'd1, 1, 0, 4'b0001));
      addRow("irq0_noinc",   mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      addRow("irq0_inc",     mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);

      reset = 1'b0;
      applyStimulus(mkIn(0, 4'b0000, 0, 4'd0, 2'd0, 0, 0));
      @(posedge clk);
      #1;

      foreach (tbl[k]) begin
         runRow(tbl[k].name, tbl[k].in, tbl[k].exp);
      end

      // Multi-word instruction with a one-cycle stall inside S_EXT.
      extEnCount = 0;
      runRow("ext_fetch", mkIn(1, 4'b0000, 0, 4'd12, 2'd0, 0, 0), oInc);
      applyStimulus(mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0));
      @(negedge clk);
      checkOutput("ext_word1", oInc);
      extEnCount += int'(bus.pc_en);
      @(posedge clk); #1;
      applyStimulus(mkIn(1, 4'b0000, 1, 4'd0, 2'd0, 0, 0));
      @(negedge clk);
      checkOutput("ext_stalled", oZero);
      extEnCount += int'(bus.pc_en);
      @(posedge clk); #1;
      applyStimulus(mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0));
      @(negedge clk);
      checkOutput("ext_word2", oInc);
      extEnCount += int'(bus.pc_en);
      @(posedge clk); #1;
      checkValue("ext_en_cycles", extEnCount, 2);
      runRow("ext_back_fetch", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);

      // RET with a request arriving during the memory wait.
      retStallCount = 0;
      runRow("ret_fetch", mkIn(1, 4'b0000, 0, 4'd11, 2'd2, 0, 0), oInc);
      applyStimulus(mkIn(1, 4'b0100, 0, 4'd11, 2'd2, 0, 0));
      @(negedge clk);
      checkOutput("ret_wait1", oStall);
      retStallCount += int'(bus.stall);
      @(posedge clk); #1;
      applyStimulus(mkIn(1, 4'b0000, 0, 4'd11, 2'd2, 0, 0));
      @(negedge clk);
      checkOutput("ret_wait2", oStall);
      retStallCount += int'(bus.stall);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("ret_wait_done", oZero);
      retStallCount += int'(bus.stall);
      @(posedge clk); #1;
      checkValue("ret_stall_cycles", retStallCount, 2);
      runRow("ret_load", mkIn(1, 4'b0000, 0, 4'd11, 2'd2, 0, 0),
             mkOut(1, 1, 2'b11, 0, 3'd0, 0, 0, 4'b0000));
      runRow("ret_irq_accept", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      runRow("ret_irq_vector", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0),
             mkOut(1, 1, 2'b01, 1, 3'd3, 1, 0, 4'b0100));
      runRow("ret_irq_noinc", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);

      // Asynchronous reset in S_WAIT with channel 0 pending.
      runRow("rr_fetch", mkIn(1, 4'b0000, 0, 4'd11, 2'd2, 0, 0), oInc);
      runRow("rr_wait1", mkIn(1, 4'b0001, 0, 4'd11, 2'd2, 0, 0), oStall);
      applyStimulus(mkIn(1, 4'b0000, 0, 4'd11, 2'd2, 0, 0));
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rr_async_reset", oRst);
      checkValue("rr_pending_clear", int'(dut.pending_q), 0);
      @(posedge clk); #1;
      runRow("rr_held",   mkIn(0, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oRst);
      runRow("rr_vector", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oRst);
      runRow("rr_noinc",  mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oZero);
      runRow("rr_no_ack1", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);
      runRow("rr_no_ack2", mkIn(1, 4'b0000, 0, 4'd0, 2'd0, 0, 0), oInc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
